dlock_ctrl: RTL and testbench

Sequencing controller for the serial digital lock datapath.
- Collects a CODE_LEN-bit serial key entry and compares it against a stored code.
- Counts consecutive failed attempts and enforces a timed lockout after MAX_FAIL failures.
- Holds unlock for a bounded open window, then auto-relocks.
- Optionally allows the stored code to be reprogrammed while open.

---
 rtl/dlock_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dlock_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlock_ctrl.sv
// Serial digital-lock sequencer: key entry, compare, fail counting, lockout and open window.
// Optional code reprogramming while open is enabled by defining DLOCK_CTRL_PROG_EN.
module dlock_ctrl #(
  parameter int                  CODE_LEN     = 6,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE = 6'b101100,
  parameter int                  MAX_FAIL     = 3,
  parameter int                  LOCKOUT_CYC  = 16,
  parameter int                  OPEN_CYC     = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       b_in,
  input  logic       b_valid,
  input  logic       abort,
  input  logic       relock,
  input  logic       prog,
  output logic       unlock,
  output logic       alarm,
  output logic [2:0] fail_cnt,
  output logic [3:0] bit_cnt
);

  localparam int TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROG    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t              state;
  logic [CODE_LEN-1:0] entry;
  logic [CODE_LEN-1:0] entry_nxt;
  logic [TW-1:0]       timer;
  logic [4:0]          cnt_nxt;
  logic                last_bit;
  logic [CODE_LEN-1:0] code;

`ifndef DLOCK_CTRL_PROG_EN
  logic unused_prog;
  assign code        = DEFAULT_CODE;
  assign unused_prog = prog;
`endif

  // bit_cnt never displays CODE_LEN itself, so the count is compared one bit wider
  assign cnt_nxt   = {1'b0, bit_cnt} + 5'd1;
  assign last_bit  = (cnt_nxt == 5'(CODE_LEN));
  assign entry_nxt = {entry[CODE_LEN-2:0], b_in};

  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      entry    <= '0;
      timer    <= '0;
      unlock   <= 1'b0;
      alarm    <= 1'b0;
      fail_cnt <= '0;
      bit_cnt  <= '0;
`ifdef DLOCK_CTRL_PROG_EN
      code     <= DEFAULT_CODE;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (b_valid) begin
            entry   <= entry_nxt;
            bit_cnt <= 4'd1;
            state   <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (abort) begin
            bit_cnt <= '0;
            state   <= S_IDLE;
          end else if (b_valid) begin
            entry <= entry_nxt;
            if (last_bit) begin
              bit_cnt <= '0;
              state   <= S_CHECK;
            end else begin
              bit_cnt <= cnt_nxt[3:0];
            end
          end
        end
        S_CHECK: begin
          if (entry == code) begin
            fail_cnt <= '0;
            timer    <= TW'(OPEN_CYC);
            unlock   <= 1'b1;
            state    <= S_OPEN;
          end else if (fail_cnt + 3'd1 == 3'(MAX_FAIL)) begin
            fail_cnt <= 3'(MAX_FAIL);
            timer    <= TW'(LOCKOUT_CYC);
            alarm    <= 1'b1;
            state    <= S_LOCKOUT;
          end else begin
            fail_cnt <= fail_cnt + 3'd1;
            state    <= S_IDLE;
          end
        end
        S_OPEN: begin
          if (relock || timer == TW'(1)) begin
            unlock <= 1'b0;
            timer  <= '0;
            state  <= S_IDLE;
          end
`ifdef DLOCK_CTRL_PROG_EN
          else if (prog) begin
            bit_cnt <= '0;
            state   <= S_PROG;
          end
`endif
          else begin
            timer <= timer - TW'(1);
          end
        end
`ifdef DLOCK_CTRL_PROG_EN
        // Open timer is held while the new code is shifted in
        S_PROG: begin
          if (abort) begin
            unlock  <= 1'b0;
            bit_cnt <= '0;
            timer   <= '0;
            state   <= S_IDLE;
          end else if (b_valid) begin
            entry <= entry_nxt;
            if (last_bit) begin
              code    <= entry_nxt;
              unlock  <= 1'b0;
              bit_cnt <= '0;
              timer   <= '0;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= cnt_nxt[3:0];
            end
          end
        end
`endif
        S_LOCKOUT: begin
          if (timer == TW'(1)) begin
            alarm    <= 1'b0;
            fail_cnt <= '0;
            timer    <= '0;
            state    <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          unlock  <= 1'b0;
          alarm   <= 1'b0;
          bit_cnt <= '0;
          timer   <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlock_ctrl.sv
// Bench for dlock_ctrl: hand-derived vector table, directed multi-cycle sequences,
// then randomized traffic against a queue/counter reference model.
module tb_dlock_ctrl;

  localparam int              CL  = 6;
  localparam logic [CL-1:0]   DEF = 6'b101100;
  localparam int              MF  = 3;
  localparam int              LC  = 16;
  localparam int              OC  = 8;
`ifdef DLOCK_CTRL_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic       clk, clear, b_in, b_valid, abort, relock, prog;
  logic       unlock, alarm;
  logic [2:0] fail_cnt;
  logic [3:0] bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dlock_ctrl dut (
    .clk(clk), .clear(clear), .b_in(b_in), .b_valid(b_valid), .abort(abort),
    .relock(relock), .prog(prog), .unlock(unlock), .alarm(alarm),
    .fail_cnt(fail_cnt), .bit_cnt(bit_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       bv, bi, ab, rl, pg;
    logic       u, a;
    logic [2:0] f;
    logic [3:0] b;
  } vec_t;
  vec_t tbl[$];

  // reference model state
  int            m_q[$];
  logic [CL-1:0] m_code;
  int            open_left, lock_left, fails;
  bit            checking, programming;

  task automatic add(input logic bv, bi, ab, rl, pg, u, a, input int f, b);
    vec_t v;
    v.bv = bv; v.bi = bi; v.ab = ab; v.rl = rl; v.pg = pg;
    v.u = u; v.a = a; v.f = 3'(f); v.b = 4'(b);
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic bv, bi, ab, rl, pg);
    b_valid = bv; b_in = bi; abort = ab; relock = rl; prog = pg;
    @(negedge clk);
    #1;
  endtask

  task automatic enter(input logic [CL-1:0] c);
    for (int i = CL - 1; i >= 0; i--) cyc(1'b1, c[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic u, a, input logic [2:0] f, input logic [3:0] b);
    n_cmp++;
    if ({unlock, alarm, fail_cnt, bit_cnt} !== {u, a, f, b}) begin
      n_bad++;
      $display("FAIL %s: got unlock=%b alarm=%b fail_cnt=%0d bit_cnt=%0d, want unlock=%b alarm=%b fail_cnt=%0d bit_cnt=%0d",
               nm, unlock, alarm, fail_cnt, bit_cnt, u, a, f, b);
    end
  endtask

  function automatic logic [CL-1:0] q_val();
    int v = 0;
    foreach (m_q[i]) v = v * 2 + m_q[i];
    return CL'(v);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_code = DEF; open_left = 0; lock_left = 0; fails = 0;
    checking = 0; programming = 0;
  endtask

  task automatic model_step(input logic bv, bi, ab, rl, pg);
    if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) fails = 0;
    end else if (checking) begin
      checking = 0;
      if (q_val() == m_code) begin fails = 0; open_left = OC; end
      else if (fails + 1 == MF) begin fails = MF; lock_left = LC; end
      else fails++;
      m_q.delete();
    end else if (programming) begin
      if (ab) begin programming = 0; open_left = 0; m_q.delete(); end
      else if (bv) begin
        m_q.push_back(int'(bi));
        if (m_q.size() == CL) begin
          m_code = q_val(); programming = 0; open_left = 0; m_q.delete();
        end
      end
    end else if (open_left > 0) begin
      if (rl || open_left == 1) open_left = 0;
      else if (pg && PROG_EN) programming = 1;
      else open_left--;
    end else begin
      if (m_q.size() > 0 && ab) m_q.delete();
      else if (bv) begin
        m_q.push_back(int'(bi));
        if (m_q.size() == CL) checking = 1;
      end
    end
  endtask

  function automatic logic [8:0] m_expect();
    logic u;
    logic [3:0] b;
    u = (open_left > 0) || programming;
    b = checking ? 4'd0 : 4'(m_q.size());
    return {u, lock_left > 0, 3'(fails), b};
  endfunction

  initial begin
    logic [CL-1:0] good, bad, alt;
    logic [8:0]    exp;
    int            ucount;
    good = DEF;
    bad  = 6'b101101;
    alt  = 6'b010011;

    // correct code, open window of OC cycles
    for (int i = 0; i < CL; i++) add(1, good[CL-1-i], 0, 0, 0, 0, 0, 0, (i == CL - 1) ? 0 : i + 1);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < OC - 1; k++) add(k == 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // three wrong attempts -> lockout, all inputs ignored while locked
    for (int a = 0; a < MF; a++) begin
      for (int i = 0; i < CL; i++) add(1, bad[CL-1-i], 0, 0, 0, 0, 0, a, (i == CL - 1) ? 0 : i + 1);
      if (a < MF - 1) add(0, 0, 0, 0, 0, 0, 0, a + 1, 0);
      else            add(0, 0, 0, 0, 0, 0, 1, MF, 0);
    end
    for (int k = 0; k < LC - 1; k++) add(1, 1, 1, 1, 1, 0, 1, MF, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // one failure, then abort with b_valid mid-entry keeps fail_cnt
    for (int i = 0; i < CL; i++) add(1, bad[CL-1-i], 0, 0, 0, 0, 0, 0, (i == CL - 1) ? 0 : i + 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1, 2);
    add(1, 1, 0, 0, 0, 0, 0, 1, 3);
    add(1, 1, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < CL; i++) add(1, good[CL-1-i], 0, 0, 0, 0, 0, 1, (i == CL - 1) ? 0 : i + 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // relock together with prog on the 3rd open cycle
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);

    b_valid = 0; b_in = 0; abort = 0; relock = 0; prog = 0;
    clear = 0;
    #2;
    chk("reset", 1'b0, 1'b0, 3'd0, 4'd0);
    #6;
    clear = 1;

    foreach (tbl[i]) begin
      cyc(tbl[i].bv, tbl[i].bi, tbl[i].ab, tbl[i].rl, tbl[i].pg);
      chk($sformatf("vec%0d", i), tbl[i].u, tbl[i].a, tbl[i].f, tbl[i].b);
    end

`ifdef DLOCK_CTRL_PROG_EN
    enter(good);
    cyc(0, 0, 0, 0, 0);
    chk("prog_open", 1'b1, 1'b0, 3'd0, 4'd0);
    cyc(0, 0, 0, 0, 1);
    chk("prog_enter", 1'b1, 1'b0, 3'd0, 4'd0);
    for (int i = CL - 1; i >= 3; i--) cyc(1, alt[i], 0, 0, 0);
    chk("prog_mid", 1'b1, 1'b0, 3'd0, 4'd3);
    for (int i = 2; i >= 0; i--) cyc(1, alt[i], 0, 0, 0);
    chk("prog_done", 1'b0, 1'b0, 3'd0, 4'd0);
    enter(good);
    cyc(0, 0, 0, 0, 0);
    chk("old_code_rejected", 1'b0, 1'b0, 3'd1, 4'd0);
    enter(alt);
    cyc(0, 0, 0, 0, 0);
    chk("new_code_accepted", 1'b1, 1'b0, 3'd0, 4'd0);
    for (int k = 0; k < OC; k++) cyc(0, 0, 0, 0, 0);
    chk("new_code_window_end", 1'b0, 1'b0, 3'd0, 4'd0);
`else
    enter(good);
    cyc(0, 0, 0, 0, 0);
    chk("noprog_open", 1'b1, 1'b0, 3'd0, 4'd0);
    cyc(1, 1, 0, 0, 1);
    chk("noprog_prog_ignored", 1'b1, 1'b0, 3'd0, 4'd0);
    ucount = 2;
    for (int k = 0; k < 20 && unlock; k++) begin
      cyc(0, 0, 0, 0, 1);
      if (unlock) ucount++;
    end
    n_cmp++;
    if (ucount != OC) begin
      n_bad++;
      $display("FAIL noprog_window: unlock lasted %0d cycles, want %0d", ucount, OC);
    end
`endif

    // asynchronous clear between edges during lockout
    for (int a = 0; a < MF; a++) begin
      enter(bad);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lockout_before_clear", 1'b0, 1'b1, 3'(MF), 4'd0);
    #3;
    clear = 0;
    #1;
    chk("async_clear", 1'b0, 1'b0, 3'd0, 4'd0);
    clear = 1;
    #1;
    enter(good);
    cyc(0, 0, 0, 0, 0);
    chk("unlock_after_clear", 1'b1, 1'b0, 3'd0, 4'd0);

    // randomized traffic against the reference model
    #2;
    clear = 0;
    #2;
    clear = 1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic bv, bi, ab, rl, pg;
      int idx;
      bv  = ($urandom % 4) != 0;
      idx = CL - 1 - m_q.size();
      if (idx >= 0 && ($urandom % 8) != 0) bi = m_code[idx];
      else bi = 1'($urandom);
      ab = ($urandom % 32) == 0;
      rl = ($urandom % 16) == 0;
      pg = ($urandom % 8) == 0;
      cyc(bv, bi, ab, rl, pg);
      model_step(bv, bi, ab, rl, pg);
      exp = m_expect();
      chk($sformatf("rand%0d", n), exp[8], exp[7], exp[6:4], exp[3:0]);
      if (($urandom % 256) == 0) begin
        #2;
        clear = 0;
        #2;
        clear = 1;
        model_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
